apb_requester: RTL and testbench

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester_pkg.sv | 17 +
 rtl/apb_addr_decoder.sv | 27 ++
 rtl/apb_requester.sv | 182 ++++++++++++++++++
 tb/tb_apb_requester.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_requester_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and the slave address map.
package apb_requester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  localparam int NUM_SLAVES = 3;

  // Element [0] is the rightmost entry of each packed list.
  localparam logic [NUM_SLAVES-1:0][31:0] SLV_BASE  = {32'h8800_0000, 32'h8400_0000, 32'h8000_0000};
  localparam logic [NUM_SLAVES-1:0][31:0] SLV_LIMIT = {32'h8BFF_FFFF, 32'h87FF_FFFF, 32'h83FF_FFFF};
  localparam logic [NUM_SLAVES-1:0][NUM_SLAVES-1:0] SLV_SEL = {3'b100, 3'b010, 3'b001};

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: one-hot slave select plus an unmapped flag.
module apb_addr_decoder
  import apb_requester_pkg::*;
(
  input  logic [31:0]           addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  unmapped_o
);

  logic [NUM_SLAVES-1:0] hit;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign hit[gi] = (addr_i >= SLV_BASE[gi]) && (addr_i <= SLV_LIMIT[gi]);
  end

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit[i]) begin
        sel_o = sel_o | SLV_SEL[i];
      end
    end
  end

  assign unmapped_o = ~|hit;

endmodule

// File: rtl/apb_requester.sv
// Command-to-APB requester with IDLE/SETUP/ACCESS FSM and one-cycle response pulse.
// Optional ACCESS wait timeout is enabled by defining APB_TIMEOUT_EN.
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  input  logic        Pslverr,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  apb_state_e  state_q, state_d;
  logic [2:0]  psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        err_pend_q, err_pend_d;

  logic [2:0]  dec_sel;
  logic        dec_unmapped;
  logic        in_access;
  logic        accept;
  logic        acc_mapped;
  logic        acc_unmapped;
  logic        timeout_hit;
  logic        complete;

  apb_addr_decoder u_decoder (
    .addr_i     (cmd_addr),
    .sel_o      (dec_sel),
    .unmapped_o (dec_unmapped)
  );

  assign in_access    = (state_q == ST_ACCESS);
  assign cmd_ready    = Hresetn & ((state_q == ST_IDLE) | (in_access & Pready));
  assign accept       = cmd_valid & cmd_ready;
  assign acc_mapped   = accept & ~dec_unmapped;
  assign acc_unmapped = accept & dec_unmapped;
  assign complete     = in_access & (Pready | timeout_hit);

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive Pready-low ACCESS cycle.
  assign timeout_hit = in_access & ~Pready & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (in_access && !Pready && !timeout_hit) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (acc_mapped) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (complete) state_d = acc_mapped ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    err_pend_d  = 1'b0;

    if (acc_mapped) begin
      psel_d    = dec_sel;
      penable_d = 1'b0;
      paddr_d   = cmd_addr;
      pwrite_d  = cmd_write;
      if (cmd_write) begin
        pwdata_d = cmd_wdata;
      end
    end else if (state_q == ST_SETUP) begin
      penable_d = 1'b1;
    end else if (complete) begin
      psel_d    = '0;
      penable_d = 1'b0;
    end

    // An unmapped accept in a completion cycle collides with that completion's
    // response, so its error pulse is deferred by one cycle.
    if (complete) begin
      rsp_valid_d = 1'b1;
      if (timeout_hit) begin
        rsp_err_d = 1'b1;
      end else begin
        rsp_err_d   = Pslverr;
        rsp_rdata_d = pwrite_q ? 32'h0 : Prdata;
      end
      err_pend_d = acc_unmapped;
    end else if (acc_unmapped || err_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      err_pend_d  = acc_unmapped & err_pend_q;
    end
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_pend_q  <= err_pend_d;
    end
  end

  assign Pselx     = psel_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios plus a randomized run
// against a transaction-level reference model with a response queue.
module tb_apb_requester;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  apb_requester #(.TIMEOUT_CYCLES(16)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .Pready    (Pready),
    .Pslverr   (Pslverr),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 Hclk = ~Hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] ref_decode(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges [6];
    int k;
    edges[0] = 32'h83FF_FFFF; edges[1] = 32'h8400_0000; edges[2] = 32'h8BFF_FFFF;
    edges[3] = 32'h8C00_0000; edges[4] = 32'h7FFF_FFFF; edges[5] = 32'h8800_0000;
    k = $urandom_range(0, 7);
    if (k <= 5) return 32'h8000_0000 + 32'(($urandom % 3) * 32'h0400_0000) + ($urandom & 32'h03FF_FFFC);
    if (k == 6) return edges[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    Pready    = 1'b0;
    Pslverr   = 1'b0;
    Prdata    = $urandom;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic test_reset();
    logic [103:0] v;
    Hresetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge Hclk);
    v = {Pselx, Penable, Pwrite, Paddr, Pwdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready};
    n_checks++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", v);
    end
    Hresetn = 1'b1;
    @(negedge Hclk);
    n_checks++;
    if ({cmd_ready, Pselx, Penable, rsp_valid} !== {1'b1, 3'b000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: ready/psel/pen/rsp got %b required 1_000_0_0",
               {cmd_ready, Pselx, Penable, rsp_valid});
    end
    $display("test_reset done");
  endtask

  task automatic test_write();
    issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    Pready = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL write_ready: got %b required 1", cmd_ready); end
    @(negedge Hclk);
    cmd_valid = 1'b0;
    n_checks++;
    if ({Pselx, Penable, Pwrite, Paddr, Pwdata, rsp_valid} !== {3'b001, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL write_setup: got %b_%b_%b_%h_%h_%b required 001_0_1_80000010_deadbeef_0",
               Pselx, Penable, Pwrite, Paddr, Pwdata, rsp_valid);
    end
    @(negedge Hclk);
    n_checks++;
    if ({Pselx, Penable, Pwrite, Paddr, Pwdata} !== {3'b001, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL write_access: got %b_%b_%b_%h_%h required 001_1_1_80000010_deadbeef",
               Pselx, Penable, Pwrite, Paddr, Pwdata);
    end
    @(negedge Hclk);
    Pready = 1'b0;
    n_checks++;
    if ({Pselx, Penable, rsp_valid, rsp_err, rsp_rdata} !== {3'b000, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL write_rsp: got psel=%b pen=%b v=%b e=%b d=%h required 000 0 1 0 00000000",
               Pselx, Penable, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge Hclk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL write_rsp_pulse: got %b required 0", rsp_valid); end
    $display("test_write done: write 80000010 <- deadbeef");
  endtask

  task automatic test_read_wait();
    issue(1'b0, 32'h8400_0004, 32'h1234_5678);
    Pready  = 1'b0;
    Pslverr = 1'b1;
    @(negedge Hclk);
    cmd_valid = 1'b0;
    n_checks++;
    if ({Pselx, Penable, Pwrite, Paddr, Pwdata} !== {3'b010, 1'b0, 1'b0, 32'h8400_0004, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL read_setup: got %b_%b_%b_%h_%h required 010_0_0_84000004_deadbeef",
               Pselx, Penable, Pwrite, Paddr, Pwdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge Hclk);
      if (i == 3) begin
        Pready  = 1'b1;
        Pslverr = 1'b0;
        Prdata  = 32'h0000_0019;
      end else begin
        Prdata = $urandom;
      end
      #1;
      n_checks++;
      if ({Pselx, Penable, Pwrite, Paddr, Pwdata, cmd_ready} !==
          {3'b010, 1'b1, 1'b0, 32'h8400_0004, 32'hDEAD_BEEF, (i == 3)}) begin
        n_fail++;
        $display("FAIL read_access_%0d: got %b_%b_%b_%h_%h_%b required 010_1_0_84000004_deadbeef_%0d",
                 i, Pselx, Penable, Pwrite, Paddr, Pwdata, cmd_ready, (i == 3));
      end
    end
    @(negedge Hclk);
    Pready = 1'b0;
    Prdata = $urandom;
    n_checks++;
    if ({Pselx, Penable, Paddr, rsp_valid, rsp_err, rsp_rdata} !== {3'b000, 1'b0, 32'h8400_0004, 1'b1, 1'b0, 32'h19}) begin
      n_fail++;
      $display("FAIL read_rsp: got psel=%b pen=%b addr=%h v=%b e=%b d=%h required 000 0 84000004 1 0 00000019",
               Pselx, Penable, Paddr, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge Hclk);
    $display("test_read_wait done: read 84000004 -> %h", 32'h19);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    w1 = $urandom;
    w2 = $urandom;
    issue(1'b1, 32'h8800_0000, w1);
    Pready = 1'b1;
    @(negedge Hclk);
    cmd_valid = 1'b0;
    n_checks++;
    if ({Pselx, Penable, Paddr, Pwdata} !== {3'b100, 1'b0, 32'h8800_0000, w1}) begin
      n_fail++;
      $display("FAIL b2b_setup1: got %b_%b_%h_%h required 100_0_88000000_%h", Pselx, Penable, Paddr, Pwdata, w1);
    end
    @(negedge Hclk);
    issue(1'b1, 32'h8800_0004, w2);
    #1;
    n_checks++;
    if ({Pselx, Penable, cmd_ready} !== {3'b100, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_access1: got psel=%b pen=%b ready=%b required 100 1 1", Pselx, Penable, cmd_ready);
    end
    @(negedge Hclk);
    cmd_valid = 1'b0;
    n_checks++;
    if ({Pselx, Penable, Paddr, Pwdata, rsp_valid, rsp_err} !== {3'b100, 1'b0, 32'h8800_0004, w2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_setup2: got %b_%b_%h_%h_%b_%b required 100_0_88000004_%h_1_0",
               Pselx, Penable, Paddr, Pwdata, rsp_valid, rsp_err, w2);
    end
    @(negedge Hclk);
    n_checks++;
    if ({Pselx, Penable, rsp_valid} !== {3'b100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_access2: got %b_%b_%b required 100_1_0", Pselx, Penable, rsp_valid);
    end
    @(negedge Hclk);
    Pready = 1'b0;
    n_checks++;
    if ({Pselx, Penable, rsp_valid, rsp_err} !== {3'b000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_rsp2: got %b_%b_%b_%b required 000_0_1_0", Pselx, Penable, rsp_valid, rsp_err);
    end
    @(negedge Hclk);
    $display("test_back_to_back done: writes 88000000, 88000004");
  endtask

  task automatic test_unmapped();
    issue(1'b0, 32'h9000_0000, 32'h0);
    Pready = 1'b1;
    Prdata = 32'hFFFF_FFFF;
    @(negedge Hclk);
    issue(1'b0, 32'h8C00_0000, 32'h0);
    #1;
    n_checks++;
    if ({Pselx, Penable, Paddr, rsp_valid, rsp_err, rsp_rdata, cmd_ready} !==
        {3'b000, 1'b0, 32'h8800_0004, 1'b1, 1'b1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL unmapped_rsp1: got %b_%b_%h_%b_%b_%h_%b required 000_0_88000004_1_1_00000000_1",
               Pselx, Penable, Paddr, rsp_valid, rsp_err, rsp_rdata, cmd_ready);
    end
    @(negedge Hclk);
    cmd_valid = 1'b0;
    n_checks++;
    if ({Pselx, Penable, rsp_valid, rsp_err, rsp_rdata} !== {3'b000, 1'b0, 1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL unmapped_rsp2: got %b_%b_%b_%b_%h required 000_0_1_1_00000000",
               Pselx, Penable, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge Hclk);
    Pready = 1'b0;
    n_checks++;
    if ({Pselx, rsp_valid} !== {3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL unmapped_quiet: got psel=%b v=%b required 000 0", Pselx, rsp_valid);
    end
    $display("test_unmapped done: reads 90000000, 8c000000");
  endtask

  task automatic test_slverr();
    logic [31:0] r;
    r = $urandom;
    issue(1'b0, 32'h8000_0000, 32'h0);
    Pready = 1'b1;
    @(negedge Hclk);
    cmd_valid = 1'b0;
    @(negedge Hclk);
    Pslverr = 1'b1;
    Prdata  = r;
    @(negedge Hclk);
    Pslverr = 1'b0;
    Pready  = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, r}) begin
      n_fail++;
      $display("FAIL slverr_rsp: got v=%b e=%b d=%h required 1 1 %h", rsp_valid, rsp_err, rsp_rdata, r);
    end
    @(negedge Hclk);
    $display("test_slverr done: read 80000000 -> err");
  endtask

  task automatic test_timeout();
    int n_acc;
    bit seen;
    n_acc = 0;
    seen  = 1'b0;
    issue(1'b0, 32'h8400_0000, 32'h0);
    Pready = 1'b0;
    @(negedge Hclk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Hclk);
      Prdata = $urandom;
      if (rsp_valid === 1'b1) seen = 1'b1;
      else if (Penable === 1'b1) n_acc++;
    end
`ifdef APB_TIMEOUT_EN
    n_checks++;
    if ({seen, n_acc, rsp_err, rsp_rdata, Pselx, Penable} !== {1'b1, 32'd16, 1'b1, 32'h0, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_abort: got seen=%b acc=%0d e=%b d=%h psel=%b pen=%b required 1 16 1 00000000 000 0",
               seen, n_acc, rsp_err, rsp_rdata, Pselx, Penable);
    end
    @(negedge Hclk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b required 0", rsp_valid); end
`else
    n_checks++;
    if ({seen, n_acc} !== {1'b0, 32'd40}) begin
      n_fail++;
      $display("FAIL no_timeout_wait: got seen=%b acc=%0d required 0 40", seen, n_acc);
    end
    Pready = 1'b1;
    Prdata = 32'h0000_005A;
    @(negedge Hclk);
    Pready = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h5A}) begin
      n_fail++;
      $display("FAIL no_timeout_done: got v=%b e=%b d=%h required 1 0 0000005a", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge Hclk);
`endif
    $display("test_timeout done: %0d access cycles", n_acc);
  endtask

  task automatic test_reset_mid();
    logic [103:0] v;
    issue(1'b0, 32'h8000_0100, 32'h0);
    Pready = 1'b0;
    @(negedge Hclk);
    cmd_valid = 1'b0;
    @(negedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b0;
    @(negedge Hclk);
    v = {Pselx, Penable, Pwrite, Paddr, Pwdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready};
    n_checks++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h required 0", v);
    end
    Hresetn = 1'b1;
    Pready  = 1'b1;
    @(negedge Hclk);
    n_checks++;
    if ({rsp_valid, cmd_ready, Pselx} !== {1'b0, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_after: got v=%b ready=%b psel=%b required 0 1 000", rsp_valid, cmd_ready, Pselx);
    end
    Pready = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [2:0]  m_psel, dec;
    logic        m_pen, m_pwrite, exp_ready, acc, cmpl;
    logic [31:0] m_paddr, m_pwdata;
    int          streak, txn;
    rsp_t        r;

    Hresetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge Hclk);
    Hresetn  = 1'b1;
    exp_q.delete();
    m_psel   = '0; m_pen = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
    streak   = 0;
    txn      = 0;

    for (int cyc = 0; cyc < 406; cyc++) begin
      n_checks++;
      if ({Pselx, Penable, Pwrite, Paddr, Pwdata} !== {m_psel, m_pen, m_pwrite, m_paddr, m_pwdata}) begin
        n_fail++;
        $display("FAIL rand_apb cyc %0d: got %b_%b_%b_%h_%h required %b_%b_%b_%h_%h", cyc,
                 Pselx, Penable, Pwrite, Paddr, Pwdata, m_psel, m_pen, m_pwrite, m_paddr, m_pwdata);
      end
      if (rsp_valid !== 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_rsp cyc %0d: got unexpected response d=%h e=%b required none", cyc, rsp_rdata, rsp_err);
        end else begin
          r = exp_q.pop_front();
          txn++;
          if ({rsp_rdata, rsp_err} !== {r.rdata, r.err}) begin
            n_fail++;
            $display("FAIL rand_rsp cyc %0d: got d=%h e=%b required d=%h e=%b", cyc, rsp_rdata, rsp_err, r.rdata, r.err);
          end else begin
            $display("txn %0d: rdata=%h err=%b", txn, rsp_rdata, rsp_err);
          end
        end
      end

      cmd_valid = ($urandom % 3) != 0;
      cmd_write = $urandom_range(0, 1);
      cmd_addr  = pick_addr();
      cmd_wdata = $urandom;
      Prdata    = $urandom;
      Pslverr   = ($urandom % 4) == 0;
      Pready    = ($urandom % 4) != 0;
      if (streak >= 8) Pready = 1'b1;
      if (cyc >= 400) begin
        cmd_valid = 1'b0;
        Pready    = 1'b1;
      end
      #1;

      // Ready when no transfer is open, or when the open access phase finishes now.
      exp_ready = (m_psel == 3'b000) | (m_pen & Pready);
      n_checks++;
      if (cmd_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_ready cyc %0d: got %b required %b", cyc, cmd_ready, exp_ready);
      end

      acc    = cmd_valid & exp_ready;
      cmpl   = m_pen & Pready;
      streak = (m_pen && !Pready) ? streak + 1 : 0;
      dec    = ref_decode(cmd_addr);
      if (cmpl) begin
        r.rdata = m_pwrite ? 32'h0 : Prdata;
        r.err   = Pslverr;
        exp_q.push_back(r);
      end
      if (acc && dec == 3'b000) begin
        r.rdata = 32'h0;
        r.err   = 1'b1;
        exp_q.push_back(r);
      end
      if (acc && dec != 3'b000) begin
        m_psel   = dec;
        m_pen    = 1'b0;
        m_paddr  = cmd_addr;
        m_pwrite = cmd_write;
        if (cmd_write) m_pwdata = cmd_wdata;
      end else if (m_psel != 3'b000 && !m_pen) begin
        m_pen = 1'b1;
      end else if (cmpl) begin
        m_psel = 3'b000;
        m_pen  = 1'b0;
      end
      @(negedge Hclk);
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d responses outstanding required 0", exp_q.size());
    end
    idle_inputs();
    $display("test_random done: %0d transactions", txn);
  endtask

  initial begin
    Hresetn = 1'b0;
    idle_inputs();
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_unmapped();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
